// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM states and half-period helper for multi_clock_divider
package clk_div_pkg;
   typedef enum logic [1:0] {IDLE, DIV, APPLY} state_t;
   localparam longint unsigned MIN_H = 1;
   function automatic longint unsigned half_period(longint unsigned base, longint unsigned speed);
      longint unsigned q;
      q = base / (2 * speed);
      return (q < MIN_H) ? MIN_H : q;
   endfunction
endpackage

// File: rtl/clk_div_calc.sv
// clk_div_calc: iterative restoring unsigned divider, one quotient bit per cycle
module clk_div_calc #(
   parameter int CNT_W = 32
) (
   input  logic             inClock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] dividend,
   input  logic [CNT_W:0]   divisor,
   output logic             done,
   output logic [CNT_W-1:0] quotient
);
   localparam int IW = $clog2(CNT_W + 1);
   logic [CNT_W:0]   rem, div_r, rem_in, dv, rem_nx;
   logic [CNT_W-1:0] q_in, q_nx;
   logic [CNT_W+1:0] trial;
   logic [IW-1:0]    iter;
   logic             ge;
   // the first iteration runs on the start edge itself, straight from the inputs
   always_comb begin
      rem_in = start ? '0 : rem;
      q_in   = start ? dividend : quotient;
      dv     = start ? divisor : div_r;
      trial  = {rem_in, q_in[CNT_W-1]};
      ge     = trial >= {1'b0, dv};
      rem_nx = ge ? (CNT_W+1)'(trial - {1'b0, dv}) : trial[CNT_W:0];
      q_nx   = CNT_W'({q_in, ge});
   end
   always_ff @(posedge inClock or negedge reset) begin
      if (!reset) begin
         rem      <= '0;
         div_r    <= '0;
         quotient <= '0;
         iter     <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem      <= rem_nx;
            quotient <= q_nx;
            div_r    <= divisor;
            iter     <= IW'(CNT_W - 1);
            done     <= (CNT_W == 1);
         end else if (iter != '0) begin
            rem      <= rem_nx;
            quotient <= q_nx;
            iter     <= iter - IW'(1);
            done     <= (iter == IW'(1));
         end
      end
   end
endmodule

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: N-channel programmable square clock / tick generator
module multi_clock_divider
   import clk_div_pkg::*;
#(
   parameter int BASE_SPEED    = 200000000,
   parameter int CHANNELS      = 4,
   parameter int SPEED_W       = 20,
   parameter int CNT_W         = 32,
   parameter int DEFAULT_SPEED = 100,
   localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                inClock,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_channel,
   input  logic [SPEED_W-1:0]  cfg_speed,
   input  logic [CHANNELS-1:0] enable,
   input  logic                sync,
   output logic [CHANNELS-1:0] outClock,
   output logic [CHANNELS-1:0] tick,
   output logic                speed_err
);
   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(half_period(BASE_SPEED, DEFAULT_SPEED));
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   state_t           state;
   logic [CH_W-1:0]  ch_r;
   logic [CNT_W-1:0] thr [CHANNELS];
   logic [CNT_W-1:0] cnt [CHANNELS];
   logic [CNT_W-1:0] quotient, h_new;
   logic             bad_req, start, done, apply;
   assign cfg_ready = (state == IDLE);
   assign bad_req   = (cfg_speed == '0) || (int'(cfg_channel) >= CHANNELS);
   assign start     = cfg_valid && cfg_ready && !bad_req;
   assign apply     = (state == APPLY);
   assign h_new     = (quotient == '0) ? CNT_W'(MIN_H) : quotient;
   clk_div_calc #(.CNT_W(CNT_W)) u_calc (
      .inClock (inClock),
      .reset   (reset),
      .start   (start),
      .dividend(CNT_W'(BASE_SPEED)),
      .divisor ((CNT_W+1)'({cfg_speed, 1'b0})),
      .done    (done),
      .quotient(quotient)
   );
   always_ff @(posedge inClock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ch_r      <= '0;
         speed_err <= 1'b0;
      end else begin
         speed_err <= 1'b0;
         case (state)
            IDLE: if (cfg_valid) begin
               if (bad_req) speed_err <= 1'b1;
               else begin
                  state <= DIV;
                  ch_r  <= cfg_channel;
               end
            end
            DIV: if (done) begin
               state     <= APPLY;
               speed_err <= (quotient == '0);
            end
            default: state <= IDLE;
         endcase
      end
   end
   // sync and disable win over counting; an APPLY keeps the current level
   always_ff @(posedge inClock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            thr[i] <= DEF_H;
            cnt[i] <= '0;
         end
         outClock <= '0;
         tick     <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (apply && int'(ch_r) == i) thr[i] <= h_new;
            if (!enable[i] || sync) begin
               cnt[i]      <= '0;
               outClock[i] <= 1'b0;
               tick[i]     <= 1'b0;
            end else if (apply && int'(ch_r) == i) begin
               cnt[i]  <= '0;
               tick[i] <= 1'b0;
            end else if (cnt[i] == thr[i] - ONE) begin
               cnt[i]      <= '0;
               outClock[i] <= ~outClock[i];
               tick[i]     <= ~outClock[i];
            end else begin
               cnt[i]  <= cnt[i] + ONE;
               tick[i] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: vector table, corner sequences and random run against a period-arithmetic model
module tb_multi_clock_divider;
   localparam int NCH  = 5;
   localparam int BASE = 1000;
   localparam int DEFH = 5;
   logic           inClock = 1'b0;
   logic           reset = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [2:0]     cfg_channel = '0;
   logic [19:0]    cfg_speed = '0;
   logic [NCH-1:0] enable = '0;
   logic           sync = 1'b0;
   logic [NCH-1:0] outClock, tick;
   logic           speed_err;
   int total = 0;
   int bad = 0;
   multi_clock_divider #(
      .BASE_SPEED(BASE), .CHANNELS(NCH), .SPEED_W(20), .CNT_W(32), .DEFAULT_SPEED(100)
   ) dut (
      .inClock(inClock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_channel(cfg_channel), .cfg_speed(cfg_speed), .enable(enable), .sync(sync),
      .outClock(outClock), .tick(tick), .speed_err(speed_err)
   );
   always #5 inClock = ~inClock;
   // model: each channel is a restart time plus starting level; output = level ^ (elapsed/H)&1
   int m_h [NCH];
   bit m_l0 [NCH];
   int m_k [NCH];
   bit m_tick [NCH];
   int m_busy = 0, m_ch = 0, m_hp = 0;
   bit m_clamp = 0, m_err = 0;
   function automatic bit lvl(int i);
      return m_l0[i] ^ bit'((m_k[i] / m_h[i]) % 2);
   endfunction
   task automatic chk(string nm, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask
   task automatic model_step();
      bit ap, cur;
      int q;
      ap = 0;
      if (!reset) begin
         m_busy = 0;
         m_err = 0;
         for (int i = 0; i < NCH; i++) begin
            m_h[i] = DEFH; m_l0[i] = 0; m_k[i] = 0; m_tick[i] = 0;
         end
         return;
      end
      m_err = 0;
      if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 1 && m_clamp) m_err = 1;
         if (m_busy == 0) ap = 1;
      end else if (cfg_valid) begin
         if (cfg_speed == 0 || int'(cfg_channel) >= NCH) m_err = 1;
         else begin
            q = BASE / (2 * int'(cfg_speed));
            m_busy = 33;
            m_clamp = (q == 0);
            m_hp = (q == 0) ? 1 : q;
            m_ch = int'(cfg_channel);
         end
      end
      for (int i = 0; i < NCH; i++) begin
         cur = lvl(i);
         if (ap && i == m_ch) m_h[i] = m_hp;
         if (!enable[i] || sync) begin
            m_l0[i] = 0; m_k[i] = 0; m_tick[i] = 0;
         end else if (ap && i == m_ch) begin
            m_l0[i] = cur; m_k[i] = 0; m_tick[i] = 0;
         end else begin
            m_k[i]++;
            m_tick[i] = lvl(i) && !cur;
         end
      end
   endtask
   task automatic cyc();
      logic [NCH-1:0] e_oc, e_tk;
      @(posedge inClock);
      model_step();
      #1;
      for (int i = 0; i < NCH; i++) begin
         e_oc[i] = lvl(i);
         e_tk[i] = m_tick[i];
      end
      chk("outClock", outClock, e_oc);
      chk("tick", tick, e_tk);
      chk("cfg_ready", cfg_ready, m_busy == 0);
      chk("speed_err", speed_err, m_err);
   endtask
   task automatic wait_tick(input int ch, input int max, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!tick[ch] && n < max);
      if (!tick[ch]) chk("tick_timeout", n, -1);
   endtask
   task automatic measure(input int ch, output int p);
      int n;
      wait_tick(ch, 2000, n);
      wait_tick(ch, 2000, p);
   endtask
   typedef struct {
      int ch; int speed; int meas_ch; int exp_busy; int exp_err; int exp_period;
   } vec_t;
   vec_t tbl [10];
   initial begin
      int p, n, busy, errs;
      tbl[0] = '{1, 50, 1, 33, 0, 20};
      tbl[1] = '{0, 0, 1, 0, 1, 20};
      tbl[2] = '{5, 100, 0, 0, 1, 10};
      tbl[3] = '{0, 600, 0, 33, 1, 2};
      tbl[4] = '{2, 7, 2, 33, 0, 142};
      tbl[5] = '{3, 250, 3, 33, 0, 4};
      tbl[6] = '{4, 500, 4, 33, 0, 2};
      tbl[7] = '{4, 501, 4, 33, 1, 2};
      tbl[8] = '{2, 3, 2, 33, 0, 332};
      tbl[9] = '{0, 100, 0, 33, 0, 10};
      repeat (3) cyc();
      chk("rst_outClock", outClock, 0);
      chk("rst_ready", cfg_ready, 1);
      enable = '1;
      reset = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         measure(c, p);
         chk("default_period", p, 10);
      end
      wait_tick(0, 50, n);
      chk("in_phase", tick, 5'h1F);
      foreach (tbl[v]) begin
         cfg_valid = 1'b1;
         cfg_channel = 3'(tbl[v].ch);
         cfg_speed = 20'(tbl[v].speed);
         cyc();
         cfg_valid = 1'b0;
         busy = 0;
         errs = 0;
         for (int t = 0; t < 60; t++) begin
            if (!cfg_ready) busy++;
            errs += int'(speed_err);
            if (cfg_ready) break;
            cyc();
         end
         chk("vec_busy", busy, tbl[v].exp_busy);
         chk("vec_err", errs, tbl[v].exp_err);
         measure(tbl[v].meas_ch, p);
         chk("vec_period", p, tbl[v].exp_period);
      end
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      repeat (13) cyc();
      enable = 5'b11011;
      repeat (7) cyc();
      chk("disabled_low", outClock[2], 0);
      enable = '1;
      wait_tick(2, 50, n);
      chk("reenable_rise", n, 5);
      repeat (7) cyc();
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      chk("sync_low", outClock, 0);
      wait_tick(0, 50, n);
      chk("sync_coincide", tick, 5'h1F);
      cfg_valid = 1'b1;
      cfg_channel = 3'd1;
      cfg_speed = 20'd50;
      cyc();
      chk("held_first_busy", cfg_ready, 0);
      repeat (33) cyc();
      chk("held_ready_back", cfg_ready, 1);
      cyc();
      chk("held_second_busy", cfg_ready, 0);
      cfg_valid = 1'b0;
      repeat (9) cyc();
      reset = 1'b0;
      repeat (3) cyc();
      chk("rst_div_ready", cfg_ready, 1);
      reset = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         measure(c, p);
         chk("post_rst_period", p, 10);
      end
      for (int t = 0; t < 4000; t++) begin
         cfg_valid = ($urandom_range(0, 9) == 0);
         cfg_channel = 3'($urandom_range(0, 7));
         cfg_speed = ($urandom_range(0, 15) == 0) ? 20'd0 : 20'($urandom_range(1, 700));
         if ($urandom_range(0, 29) == 0) enable[$urandom_range(0, NCH-1)] ^= 1'b1;
         sync = ($urandom_range(0, 99) == 0);
         reset = ($urandom_range(0, 999) != 0);
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
